// File: rtl/radix4_sd_pkg.sv
// rtl/radix4_sd_pkg.sv - shared constants, FSM encoding and width helper for the radix-4 on-the-fly converter
package radix4_sd_pkg;

    localparam int RADIX   = 4;
    localparam int DIGIT_W = 3;
    localparam int DIG_MIN = -3;
    localparam int DIG_MAX = 3;
    localparam logic [DIGIT_W-1:0] DIG_ILLEGAL = 3'b100;

    typedef enum logic {
        ACCEPT = 1'b0,
        DONE   = 1'b1
    } state_t;

    function automatic int res_w(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/radix4_otf_digit_append.sv
// rtl/radix4_otf_digit_append.sv - combinational Q/QM update for one radix-4 signed digit
module radix4_otf_digit_append
    import radix4_sd_pkg::*;
#(
    parameter int w       = 9,
    parameter int digit_w = DIGIT_W,
    parameter int radix   = RADIX
) (
    input  logic [w-1:0]       q_cur,
    input  logic [w-1:0]       qm_cur,
    input  logic [digit_w-1:0] digit,
    output logic [w-1:0]       q_next,
    output logic [w-1:0]       qm_next
);

    localparam int SHIFT = $clog2(radix);

    logic [w-1:0] dig_ext;
    logic [w-1:0] q_sh;
    logic [w-1:0] qm_sh;

    always_comb begin
        dig_ext = {{(w-digit_w){digit[digit_w-1]}}, digit};
        q_sh    = q_cur << SHIFT;
        qm_sh   = qm_cur << SHIFT;
        q_next  = q_sh;
        qm_next = qm_sh + w'(radix - 1);
        // Negative digits borrow from QM so no carry ever has to ripple into Q.
        if (digit[digit_w-1]) begin
            q_next  = qm_sh + w'(radix) + dig_ext;
            qm_next = qm_sh + w'(radix - 1) + dig_ext;
        end else if (digit != '0) begin
            q_next  = q_sh + dig_ext;
            qm_next = q_sh + dig_ext - w'(1);
        end
    end

endmodule

// File: rtl/radix4_otf_converter.sv
// rtl/radix4_otf_converter.sv - MSD-first radix-4 signed-digit to two's-complement on-the-fly converter
// Optional illegal-digit checker: RADIX4_DIGIT_CHECK_EN
module radix4_otf_converter
    import radix4_sd_pkg::*;
#(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = DIGIT_W,
    parameter int radix        = RADIX
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic [radix_bits-1:0]              in_digit,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [res_w(no_of_digits)-1:0]     out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               err
);

    localparam int W     = res_w(no_of_digits);
    localparam int CNT_W = $clog2(no_of_digits + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(no_of_digits - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     q_reg;
    logic [W-1:0]     qm_reg;
    logic [W-1:0]     q_nxt;
    logic [W-1:0]     qm_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;

    assign accept = in_valid && in_ready;
    assign last   = accept && (cnt == LAST);

    radix4_otf_digit_append #(
        .w       (W),
        .digit_w (radix_bits),
        .radix   (radix)
    ) u_append (
        .q_cur   (q_reg),
        .qm_cur  (qm_reg),
        .digit   (in_digit),
        .q_next  (q_nxt),
        .qm_next (qm_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCEPT;
        end else if (clr) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT:  if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCEPT);
        out_valid = (state == DONE);
    end

    // Q/QM re-arm on the final digit so the next word starts clean after the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg    <= '0;
            qm_reg   <= '1;
            cnt      <= '0;
            out_data <= '0;
        end else if (clr) begin
            q_reg  <= '0;
            qm_reg <= '1;
            cnt    <= '0;
        end else if (accept) begin
            if (last) begin
                out_data <= q_nxt;
                q_reg    <= '0;
                qm_reg   <= '1;
                cnt      <= '0;
            end else begin
                q_reg  <= q_nxt;
                qm_reg <= qm_nxt;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef RADIX4_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (out_valid && out_ready) begin
            err <= 1'b0;
        end else if (accept && (in_digit == DIG_ILLEGAL)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_radix4_otf_converter.sv
// tb/tb_radix4_otf_converter.sv - scoreboard bench for radix4_otf_converter
module tb_radix4_otf_converter;

    localparam int N = 4;
    localparam int W = 9;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic [2:0]   in_digit;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   rand_ready  = 0;
    bit   ready_force = 1;
    bit   throttle    = 0;

    radix4_otf_converter #(.no_of_digits(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_digit  (in_digit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_err", err, e.err);
            end
        end
    end

    task automatic send_digit(input int d);
        int n;
        if (throttle) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_digit = 3'(d);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_digit = 3'($urandom);
    endtask

    task automatic send_word(input int d0, input int d1, input int d2, input int d3);
        int   d[4];
        int   sum;
        exp_t e;
        d = '{d0, d1, d2, d3};
        sum = 0;
        e.err = 1'b0;
        foreach (d[i]) begin
            sum = sum * 4 + d[i];
`ifdef RADIX4_DIGIT_CHECK_EN
            if (d[i] == -4) e.err = 1'b1;
`endif
        end
        e.data = W'(sum);
        sb.push_back(e);
        foreach (d[i]) send_digit(d[i]);
        chk("lat_valid", out_valid, 32'd1);
        chk("lat_ready", in_ready, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_digit = 3'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_err", err, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1..T3
        send_word(1, 0, 0, 0);
        send_word(1, -3, 0, 2);
        send_word(3, 3, 3, 3);
        send_word(-3, -3, -3, -3);
        send_word(0, 0, 0, -1);
        drain();

        // T4: hold under backpressure
        ready_force = 0;
        send_word(1, -3, 0, 2);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 32'd1);
            chk("hold_data", out_data, 32'h012);
            chk("hold_ready", in_ready, 32'd0);
        end
        @(posedge clk);
        #1;
        ready_force = 1;
        @(posedge clk);
        #1;
        chk("post_hs_ready", in_ready, 32'd1);
        chk("post_hs_valid", out_valid, 32'd0);
        send_word(3, 3, 3, 3);
        drain();

        // T5: clr mid-word, then async reset mid-word
        send_digit(3);
        send_digit(-2);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        send_word(0, 0, 1, 0);
        drain();
        send_digit(2);
        send_digit(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 32'd1);
        chk("arst_out_valid", out_valid, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_err", err, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(0, 0, 2, -1);
        drain();

`ifdef RADIX4_DIGIT_CHECK_EN
        // T6: illegal digit in position 2
        begin
            exp_t e;
            e.data = W'(68);
            e.err  = 1'b1;
            sb.push_back(e);
        end
        ready_force = 0;
        send_digit(2);
        chk("err_pre", err, 32'd0);
        send_digit(-4);
        chk("err_set", err, 32'd1);
        send_digit(1);
        send_digit(0);
        repeat (3) begin
            @(negedge clk);
            chk("err_hold", err, 32'd1);
        end
        @(posedge clk);
        #1;
        ready_force = 1;
        @(posedge clk);
        #1;
        chk("err_clear", err, 32'd0);
`else
        chk("err_off", err, 32'd0);
`endif

        // Random throttled traffic
        throttle   = 1;
        rand_ready = 1;
        for (int k = 0; k < 1000; k++) begin
            send_word($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3,
                      $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
        end
        rand_ready  = 0;
        ready_force = 1;
        throttle    = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
